// File: rtl/mux32_arbiter_pkg.sv
// Shared constants and helpers for the two-requester mux arbiter.
// Pure declarations, no latency.
// No flow control lives here; the grant helper is a pure function of its inputs.
package mux32_arbiter_pkg;

   // Source identifiers, also the mux select encoding.
   localparam logic SRC_REQ0 = 1'b0;
   localparam logic SRC_REQ1 = 1'b1;

   // Default datapath and counter widths.
   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 16;

   // Result of one arbitration decision.
   typedef struct packed {
      logic vld;   // some requester is granted this cycle
      logic src;   // which one (meaningful only when vld)
   } grant_t;

   // Round-robin pick: a lone requester always wins; on a tie the source
   // that was not granted last time wins.
   function automatic grant_t arb_pick(input logic v0,
                                       input logic v1,
                                       input logic last);
      grant_t g;
      g.vld = v0 | v1;
      g.src = last;
      if (v0 && v1) begin
         g.src = ~last;
      end else if (v0) begin
         g.src = SRC_REQ0;
      end else if (v1) begin
         g.src = SRC_REQ1;
      end
      return g;
   endfunction

endpackage

// File: rtl/mux32_arbiter_mux.sv
// Bit-sliced 2:1 word mux shared by both requesters (ctl=0 picks I0).
// Purely combinational, zero latency.
// No flow control; the arbiter decides when the output is captured.
module MUX32LAYERS2BY1
   import mux32_arbiter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             ctl,
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   output logic [WIDTH-1:0] O
);

   // One 2:1 cell per bit, all sharing the same select.
   for (genvar b = 0; b < WIDTH; b++) begin : g_layer
      assign O[b] = ctl ? I1[b] : I0[b];
   end

endmodule

// File: rtl/mux32_arbiter.sv
// Round-robin arbiter sharing one word mux between two valid/ready requesters.
// Latency 1 cycle: a word accepted at an edge is on out_data right after it.
// Backpressure: a full output stage with out_ready low withholds both readies.
module mux32_arbiter
   import mux32_arbiter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   input  logic             out_ready,
   output logic             sel,
   output logic [CNT_W-1:0] grant_cnt0,
   output logic [CNT_W-1:0] grant_cnt1
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             last;
   logic             load_en;
   logic             take;
   grant_t           grant;
   logic [WIDTH-1:0] mux_out;

   // Arbitration, select and ready generation for the current cycle.
   always_comb begin
      load_en    = ~out_valid | out_ready;
      grant      = arb_pick(req0_valid, req1_valid, last);
      // Hold the previous select when idle so the mux does not toggle.
      sel        = grant.vld ? grant.src : last;
      take       = rst_n & load_en & grant.vld;
      req0_ready = take & (grant.src == SRC_REQ0);
      req1_ready = take & (grant.src == SRC_REQ1);
   end

   MUX32LAYERS2BY1 #(
      .WIDTH (WIDTH)
   ) u_mux (
      .ctl (sel),
      .I0  (req0_data),
      .I1  (req1_data),
      .O   (mux_out)
   );

   // Output register stage: load on a grant, otherwise drain when consumed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= SRC_REQ0;
      end else if (take) begin
         out_valid <= 1'b1;
         out_data  <= mux_out;
         out_src   <= grant.src;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Round-robin pointer; resets to req1 so req0 wins the first tie.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last <= SRC_REQ1;
      end else if (take) begin
         last <= grant.src;
      end
   end

   // Per-source accepted-word counters, wrapping without saturation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else if (take) begin
         if (grant.src == SRC_REQ0) begin
            grant_cnt0 <= grant_cnt0 + CNT_ONE;
         end else begin
            grant_cnt1 <= grant_cnt1 + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_mux32_arbiter.sv
// Directed bench for mux32_arbiter with a cycle-level reference model.
// Inputs change 2 time units after each rising edge; outputs compared on the falling edge.
// Directed phases also pin literal expectations at key points.
module tb_mux32_arbiter;

   localparam int WIDTH = 32;
   localparam int CNT_W = 16;
   localparam int MOD   = 2 ** CNT_W;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req0_valid, req1_valid;
   logic [WIDTH-1:0] req0_data, req1_data;
   logic             req0_ready, req1_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_src;
   logic             out_ready;
   logic             sel;
   logic [CNT_W-1:0] grant_cnt0, grant_cnt1;

   int n_cmp = 0;
   int n_bad = 0;
   bit check_en = 1'b0;

   // Reference model state
   bit             m_valid;
   bit [WIDTH-1:0] m_data;
   bit             m_src;
   bit             m_last;
   int             m_cnt0, m_cnt1;

   always #5 clk = ~clk;

   mux32_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_src    (out_src),
      .out_ready  (out_ready),
      .sel        (sel),
      .grant_cnt0 (grant_cnt0),
      .grant_cnt1 (grant_cnt1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Which source must win: -1 none, 0 or 1.
   function automatic int want_src(bit v0, bit v1, bit last);
      if (v0 && v1) return last ? 0 : 1;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   // Model advance on each rising edge, from the inputs held during the cycle.
   always @(posedge clk) begin
      int w;
      if (!rst_n) begin
         m_valid = 0; m_data = '0; m_src = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
      end else begin
         w = want_src(req0_valid, req1_valid, m_last);
         if ((!m_valid || out_ready) && w >= 0) begin
            m_data  = (w == 1) ? req1_data : req0_data;
            m_src   = (w == 1);
            m_valid = 1;
            m_last  = (w == 1);
            if (w == 1) m_cnt1 = (m_cnt1 + 1) % MOD;
            else        m_cnt0 = (m_cnt0 + 1) % MOD;
         end else if (m_valid && out_ready) begin
            m_valid = 0;
         end
      end
   end

   // Compare every DUT output against the model mid-cycle.
   always @(negedge clk) begin
      int  w;
      bit  can;
      if (check_en) begin
         w   = want_src(req0_valid, req1_valid, m_last);
         can = rst_n && (!m_valid || out_ready);
         chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
         if (m_valid) begin
            chk("out_data", out_data, m_data);
            chk("out_src", {31'b0, out_src}, {31'b0, m_src});
         end
         chk("grant_cnt0", {16'b0, grant_cnt0}, m_cnt0);
         chk("grant_cnt1", {16'b0, grant_cnt1}, m_cnt1);
         chk("req0_ready", {31'b0, req0_ready}, {31'b0, can && (w == 0)});
         chk("req1_ready", {31'b0, req1_ready}, {31'b0, can && (w == 1)});
         chk("sel", {31'b0, sel}, (w >= 0) ? w : {31'b0, m_last});
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

   initial begin
      logic [0:0] srcs[$];
      logic [0:0] exp_srcs [4];
      exp_srcs = '{1'b0, 1'b1, 1'b0, 1'b1};

      rst_n = 0; out_ready = 1;
      req0_valid = 1; req1_valid = 1;
      req0_data = 32'h1111_1111; req1_data = 32'h2222_2222;
      tick();
      check_en = 1;
      #1;
      chk("rst_ready0", {31'b0, req0_ready}, 0);
      chk("rst_ready1", {31'b0, req1_ready}, 0);
      tick();
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_cnt0", {16'b0, grant_cnt0}, 0);

      // Idle after reset: select follows last=1.
      req0_valid = 0; req1_valid = 0; rst_n = 1;
      #1; chk("idle_sel", {31'b0, sel}, 1);

      // Ties alternate 0,1,0,1 starting with req0.
      tick();
      req0_valid = 1; req1_valid = 1;
      req0_data = 32'hAAAA_0000; req1_data = 32'h5555_FFFF;
      for (int i = 0; i < 4; i++) begin
         tick();
         srcs.push_back(out_src);
         chk("tie_data", out_data, exp_srcs[i] ? 32'h5555_FFFF : 32'hAAAA_0000);
      end
      req0_valid = 0; req1_valid = 0;
      for (int i = 0; i < 4; i++) chk("tie_src_seq", {31'b0, srcs[i]}, {31'b0, exp_srcs[i]});
      chk("tie_cnt0", {16'b0, grant_cnt0}, 2);
      chk("tie_cnt1", {16'b0, grant_cnt1}, 2);

      // Lone req1: granted every cycle with no bubble.
      req1_valid = 1; req1_data = 32'h0000_0101;
      for (int i = 0; i < 3; i++) begin
         #1; chk("lone1_ready", {31'b0, req1_ready}, 1);
         tick();
         chk("lone1_valid", {31'b0, out_valid}, 1);
         chk("lone1_src", {31'b0, out_src}, 1);
         req1_data = req1_data + 1;
      end
      req1_valid = 0;
      tick();

      // Stall: held word stays put, no readies while blocked.
      req0_valid = 1; req0_data = 32'h1234_5678;
      tick();
      out_ready = 0;
      req0_data = 32'hDEAD_0001; req1_valid = 1; req1_data = 32'hCAFE_0002;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_ready0", {31'b0, req0_ready}, 0);
         chk("stall_ready1", {31'b0, req1_ready}, 0);
         tick();
         chk("stall_data", out_data, 32'h1234_5678);
      end
      out_ready = 1;
      tick();
      chk("release_data", out_data, 32'hCAFE_0002);
      chk("release_src", {31'b0, out_src}, 1);

      // Drain and load in the same cycle.
      req1_valid = 0; req0_data = 32'h0BAD_F00D;
      #1; chk("dl_ready0", {31'b0, req0_ready}, 1);
      tick();
      chk("dl_valid", {31'b0, out_valid}, 1);
      chk("dl_data", out_data, 32'h0BAD_F00D);

      // Bring cnt0 to 7, then reset mid-operation.
      for (int i = 0; i < 3; i++) tick();
      chk("pre_rst_cnt0", {16'b0, grant_cnt0}, 7);
      chk("pre_rst_valid", {31'b0, out_valid}, 1);
      rst_n = 0; out_ready = 0; req1_valid = 1;
      #1;
      chk("midrst_ready0", {31'b0, req0_ready}, 0);
      chk("midrst_ready1", {31'b0, req1_ready}, 0);
      tick();
      chk("midrst_valid", {31'b0, out_valid}, 0);
      chk("midrst_cnt0", {16'b0, grant_cnt0}, 0);
      chk("midrst_cnt1", {16'b0, grant_cnt1}, 0);
      rst_n = 1; out_ready = 1;
      tick();
      chk("post_rst_tie_src", {31'b0, out_src}, 0);

      // Counter wrap after 65535 + 1 req0 grants.
      rst_n = 0; req1_valid = 0;
      tick();
      rst_n = 1;
      for (int i = 0; i < MOD - 1; i++) tick();
      chk("cnt0_max", {16'b0, grant_cnt0}, 32'h0000_FFFF);
      tick();
      chk("cnt0_wrap", {16'b0, grant_cnt0}, 0);
      req0_valid = 0;
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mux32_arbiter.md
# mux32_arbiter

Round-robin arbiter that shares one 32-bit 2:1 operand/result mux between two valid/ready requesters. It drives the mux select and registers the chosen word into a one-entry output stage. It sits between the two ALU-side producers and the downstream consumer of the shared 32-bit bus. Per-source grant counters are provided for debug and fairness checks.

## Interface
- Reset is synchronous, active-low, on `rst_n`; the block has one clock, `clk`.
- `WIDTH`, default 32: data width of each requester and of the output.
- `CNT_W`, default 16: width of each grant counter.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `req0_valid`  in  1  requester 0 has a word.
- `req0_data`  in  WIDTH  requester 0 word.
- `req0_ready`  out  1  requester 0 word accepted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: same as above, for requester 1.
- `out_valid`  out  1  output stage holds a word.
- `out_data`  out  WIDTH  registered selected word.
- `out_src`  out  1  source of `out_data` (0 = req0, 1 = req1).
- `out_ready`  in  1  consumer accepts `out_data`.
- `sel`  out  1  combinational mux select this cycle (0 = req0, 1 = req1).
- `grant_cnt0`, `grant_cnt1`  out  CNT_W  number of accepted words per source.

## Operation
- `load_en = !out_valid || out_ready`: the output stage can take a word this cycle.
- Grant rule:
  - Only req0 valid: grant 0.
  - Only req1 valid: grant 1.
  - Both valid: grant `!last`, where `last` is the previously granted source.
  - Neither valid: no grant.
- `sel` equals the granted source. With no grant, `sel` holds `last`, so the mux does not toggle needlessly.
- `reqN_ready = rst_n && load_en && grant == N`. At most one ready is high per cycle.
- On a grant with `load_en`:
  - `out_data` ← mux output, `out_src` ← grant, `out_valid` ← 1.
  - `last` ← grant.
  - `grant_cntN` increments by 1 and wraps modulo 2^CNT_W.
- `out_valid && out_ready` with no new grant: `out_valid` ← 0. `out_data` and `out_src` hold their last values.
- `out_valid && !out_ready`: `out_data` and `out_src` are stable, and no ready is issued.
- Requesters may drop `valid` without a handshake. The arbiter samples valid only in the current cycle.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_src`=0, `last`=1 (so req0 wins the first tie), `grant_cnt0`=`grant_cnt1`=0. `sel`=1 while idle after reset, following `last`.
- Latency is 1 cycle: a word accepted at edge k appears on `out_data` with `out_valid`=1 after edge k.
- Throughput is one word per cycle. Drain and load in the same cycle is required, with no bubble.
- Back-to-back ties alternate 0,1,0,1. A lone requester is granted every cycle with no idle cycle.
- While `rst_n`=0, both readies are 0 regardless of `out_ready`.
- Reset mid-operation discards any held output word (`out_valid`=0 after the edge). It also restores `last`=1 and clears the counters.
- Counter wrap: at `2^CNT_W-1` plus one grant, the counter becomes 0. There is no saturation flag.

## Structure
- Shared package or include (`gateConstants.v` style):
  - `SRC_REQ0`=0, `SRC_REQ1`=1.
  - Default `WIDTH`/`CNT_W`.
- One sub-module: the existing 32-bit 2:1 mux `MUX32LAYERS2BY1`, with `ctl`=`sel`, `I0`=`req0_data`, `I1`=`req1_data`.
- The arbiter owns:
  - the grant logic;
  - the `last` pointer flop;
  - the output register stage;
  - the two counters.

## Test plan
- Reset, then both valid with data 0xAAAA_0000 / 0x5555_FFFF and `out_ready`=1 for 4 cycles. Required: `out_src` sequence 0,1,0,1; `out_data` alternates accordingly; `grant_cnt0`=`grant_cnt1`=2.
- Only req1 valid, 3 cycles, `out_ready`=1. Required: `req1_ready`=1 each cycle, 3 consecutive outputs from src 1, no bubble.
- Load 0x1234_5678, then `out_ready`=0 for 5 cycles with both valid. Required: both readies 0, `out_data` stable at 0x1234_5678; on release, the next word appears one cycle later.
- Output full with `out_ready`=1 and req0 valid in the same cycle. Required: simultaneous drain and load, `out_valid` stays 1, new word after the edge.
- `rst_n`=0 for 1 cycle while `out_valid`=1 and `grant_cnt0`=7. Required: `out_valid`=0 and counters 0 after the edge; readies 0 during reset; the first post-reset tie is won by req0.
- Preload `grant_cnt0` to 0xFFFF via 65535 grants, then one more req0 grant. Required: `grant_cnt0`=0x0000.
